// File: rtl/sbus_pkg.sv
// sbus_pkg: shared SBUS memory-phase types plus the data parity helper.
// Imported by sbus_rd_master.
package sbus_pkg;

  typedef logic [14:35] tSbusAdr;
  typedef logic [0:3]   tWordMask;
  typedef logic [0:35]  tWord;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STRT = 2'd1,
    XFER = 2'd2,
    FIN  = 2'd3
  } tRdState;

  // DATA_PAR is good when it equals the XOR of all 36 data bits.
  function automatic logic word_parity(input tWord w);
    return ^w;
  endfunction

endpackage

// File: rtl/sbus_rd_master.sv
// sbus_rd_master: SBUS read-side master for one memory phase (A or B).
// Optional data parity checking is built when SBUS_PARITY_CHK_EN is defined.
module sbus_rd_master
  import sbus_pkg::*;
#(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         CROBAR,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [14:35] req_adr,
  input  logic [0:3]   req_rq,
  output logic         START,
  output logic [14:35] ADR,
  output logic [0:3]   RQ,
  input  logic         ACKN,
  input  logic         DATA_VALID,
  input  logic [0:35]  D,
  input  logic         DATA_PAR,
  output logic         rd_valid,
  output logic [0:35]  rd_data,
  output logic [34:35] rd_wo,
  output logic         done,
  output logic         nxm,
  output logic         par_err
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ZERO = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  tRdState          state_r, state_s;
  tSbusAdr          adr_r, adr_s;
  tWordMask         rq_r, rq_s;
  tWordMask         pend_r, pend_s;
  logic [1:0]       wo_r, wo_s;
  logic [TMO_W-1:0] tmo_r, tmo_s;
  logic             par_sticky_r, par_sticky_s;
  logic             ready_r, ready_s;
  logic             start_r, start_s;
  logic             rd_valid_r, rd_valid_s;
  tWord             rd_data_r, rd_data_s;
  logic [1:0]       rd_wo_r, rd_wo_s;
  logic             done_r, done_s;
  logic             nxm_r, nxm_s;
  logic             par_err_r, par_err_s;
  logic             abort_s;
  logic             bad_par_s;

`ifdef SBUS_PARITY_CHK_EN
  assign bad_par_s = (DATA_PAR != word_parity(D));
`else
  logic unused_par_s;
  assign unused_par_s = DATA_PAR;
  assign bad_par_s    = 1'b0;
`endif

  // Next-state and next-output decode for the read transfer.
  always_comb begin
    state_s      = state_r;
    adr_s        = adr_r;
    rq_s         = rq_r;
    pend_s       = pend_r;
    wo_s         = wo_r;
    tmo_s        = tmo_r;
    par_sticky_s = par_sticky_r;
    start_s      = 1'b0;
    rd_valid_s   = 1'b0;
    rd_data_s    = rd_data_r;
    rd_wo_s      = rd_wo_r;
    done_s       = 1'b0;
    nxm_s        = 1'b0;
    par_err_s    = 1'b0;
    abort_s      = 1'b0;

    case (state_r)
      IDLE: begin
        if (req_valid) begin
          adr_s        = req_adr;
          rq_s         = req_rq;
          wo_s         = req_adr[34:35];
          pend_s       = req_rq;
          tmo_s        = TMO_ZERO;
          par_sticky_s = 1'b0;
          if (req_rq == 4'b0000) begin
            state_s = FIN;
            done_s  = 1'b1;
          end else begin
            state_s = STRT;
            start_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end

      // The START clock counts as the first clock waited for ACKN.
      STRT: begin
        tmo_s   = tmo_r + TMO_ONE;
        state_s = XFER;
      end

      XFER: begin
        if (pend_r[0] && DATA_VALID) begin
          rd_valid_s   = 1'b1;
          rd_data_s    = D;
          rd_wo_s      = wo_r;
          par_sticky_s = par_sticky_r | bad_par_s;
        end else begin
          rd_valid_s   = 1'b0;
        end

        // Unrequested slots advance like acknowledged ones so wo tracks memory.
        if (!pend_r[0] || ACKN) begin
          pend_s = {pend_r[1:3], 1'b0};
          wo_s   = wo_r + 2'd1;
          if (pend_r[0]) begin
            tmo_s = TMO_ZERO;
          end else begin
            tmo_s = tmo_r;
          end
        end else if (tmo_r == TMO_LAST) begin
          pend_s  = 4'b0000;
          abort_s = 1'b1;
        end else begin
          tmo_s = tmo_r + TMO_ONE;
        end

        if (pend_s == 4'b0000) begin
          state_s   = FIN;
          done_s    = 1'b1;
          nxm_s     = abort_s;
          par_err_s = par_sticky_s;
        end else begin
          state_s = XFER;
        end
      end

      FIN: begin
        state_s      = IDLE;
        tmo_s        = TMO_ZERO;
        par_sticky_s = 1'b0;
      end

      default: begin
        state_s = IDLE;
      end
    endcase

    ready_s = (state_s == IDLE);
  end

  // State and registered outputs; CROBAR clears everything immediately.
  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      state_r      <= IDLE;
      adr_r        <= 22'd0;
      rq_r         <= 4'b0000;
      pend_r       <= 4'b0000;
      wo_r         <= 2'd0;
      tmo_r        <= TMO_ZERO;
      par_sticky_r <= 1'b0;
      ready_r      <= 1'b1;
      start_r      <= 1'b0;
      rd_valid_r   <= 1'b0;
      rd_data_r    <= 36'd0;
      rd_wo_r      <= 2'd0;
      done_r       <= 1'b0;
      nxm_r        <= 1'b0;
      par_err_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      adr_r        <= adr_s;
      rq_r         <= rq_s;
      pend_r       <= pend_s;
      wo_r         <= wo_s;
      tmo_r        <= tmo_s;
      par_sticky_r <= par_sticky_s;
      ready_r      <= ready_s;
      start_r      <= start_s;
      rd_valid_r   <= rd_valid_s;
      rd_data_r    <= rd_data_s;
      rd_wo_r      <= rd_wo_s;
      done_r       <= done_s;
      nxm_r        <= nxm_s;
      par_err_r    <= par_err_s;
    end
  end

  assign req_ready = ready_r;
  assign START     = start_r;
  assign ADR       = adr_r;
  assign RQ        = rq_r;
  assign rd_valid  = rd_valid_r;
  assign rd_data   = rd_data_r;
  assign rd_wo     = rd_wo_r;
  assign done      = done_r;
  assign nxm       = nxm_r;
  assign par_err   = par_err_r;

endmodule

// File: tb/tb_sbus_rd_master.sv
// tb_sbus_rd_master: directed self-checking bench for sbus_rd_master.
// Parity expectations follow SBUS_PARITY_CHK_EN when it is defined for the build.
module tb_sbus_rd_master;

  logic         clk = 1'b0;
  logic         CROBAR;
  logic         req_valid;
  logic         req_ready;
  logic [14:35] req_adr;
  logic [0:3]   req_rq;
  logic         START;
  logic [14:35] ADR;
  logic [0:3]   RQ;
  logic         ACKN;
  logic         DATA_VALID;
  logic [0:35]  D;
  logic         DATA_PAR;
  logic         rd_valid;
  logic [0:35]  rd_data;
  logic [34:35] rd_wo;
  logic         done;
  logic         nxm;
  logic         par_err;

  int n_checks = 0;
  int n_fail   = 0;

  int          obs_n, obs_start_cyc, obs_start_cnt, obs_done_cyc, obs_first_rv;
  logic [0:35] obs_data [4];
  logic [1:0]  obs_wo   [4];
  logic        obs_nxm, obs_par;
  bit          obs_hold_ok;

  sbus_rd_master #(.ACK_TIMEOUT(64)) dut (
    .clk(clk), .CROBAR(CROBAR),
    .req_valid(req_valid), .req_ready(req_ready), .req_adr(req_adr), .req_rq(req_rq),
    .START(START), .ADR(ADR), .RQ(RQ),
    .ACKN(ACKN), .DATA_VALID(DATA_VALID), .D(D), .DATA_PAR(DATA_PAR),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_wo(rd_wo),
    .done(done), .nxm(nxm), .par_err(par_err)
  );

  always #5 clk = ~clk;

  // Issue one request and play memory: from the clock after START, slot k is acked
  // with word dbase+wo. Observations are sampled on negedges; cycle 0 is the one after accept.
  task automatic run_xfer(input logic [14:35] adr, input logic [0:3] rq, input logic [0:35] dbase,
                          input bit ack_on, input int flip_slot, input int budget);
    int k;
    bit started;
    logic [1:0] wo;
    k = 0; started = 0;
    obs_n = 0; obs_start_cyc = -1; obs_start_cnt = 0; obs_done_cyc = -1; obs_first_rv = -1;
    obs_nxm = 1'b0; obs_par = 1'b0; obs_hold_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin obs_data[i] = 'x; obs_wo[i] = 'x; end
    @(negedge clk);
    req_valid = 1'b1; req_adr = adr; req_rq = rq;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (START) begin obs_start_cnt++; if (obs_start_cyc < 0) obs_start_cyc = c; end
      if (rd_valid) begin
        if (obs_n < 4) begin obs_data[obs_n] = rd_data; obs_wo[obs_n] = rd_wo; end
        if (obs_first_rv < 0) obs_first_rv = c;
        obs_n++;
      end
      if (ADR !== adr || RQ !== rq) obs_hold_ok = 1'b0;
      if (done) begin obs_done_cyc = c; obs_nxm = nxm; obs_par = par_err; end
      ACKN = 1'b0; DATA_VALID = 1'b0; D = 36'd0; DATA_PAR = 1'b0;
      if (started && ack_on && k < 4) begin
        wo = adr[34:35] + 2'(k);
        D = dbase + 36'(wo);
        DATA_PAR = (^D) ^ (k == flip_slot);
        ACKN = 1'b1; DATA_VALID = 1'b1;
        k++;
      end
      if (START) started = 1;
      if (obs_done_cyc >= 0) break;
      @(negedge clk);
    end
    ACKN = 1'b0; DATA_VALID = 1'b0; D = 36'd0; DATA_PAR = 1'b0;
  endtask

  task automatic test_reset();
    CROBAR = 1'b0;
    #1 CROBAR = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_checks++; if (START !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", START); end
    n_checks++; if (rd_valid !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: rd_valid %b done %b want 0 0", rd_valid, done); end
    n_checks++; if (nxm !== 1'b0 || par_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: nxm %b par_err %b want 0 0", nxm, par_err); end
    n_checks++; if (ADR !== 22'd0 || RQ !== 4'b0000) begin n_fail++; $display("FAIL reset_adr_rq: ADR %o RQ %b want 0 0000", ADR, RQ); end
    n_checks++; if (rd_data !== 36'd0 || rd_wo !== 2'd0) begin n_fail++; $display("FAIL reset_rd: data %o wo %0d want 0 0", rd_data, rd_wo); end
    CROBAR = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_quad();
    logic [1:0]  exp_wo [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
    logic [0:35] exp_d  [4] = '{36'd3, 36'd4, 36'd1, 36'd2};
    run_xfer(22'o1002, 4'b1111, 36'd1, 1'b1, -1, 40);
    n_checks++; if (obs_start_cyc !== 0 || obs_start_cnt !== 1) begin n_fail++; $display("FAIL quad_start: cyc %0d cnt %0d want 0 1", obs_start_cyc, obs_start_cnt); end
    n_checks++; if (obs_first_rv !== 2) begin n_fail++; $display("FAIL quad_latency: first rd_valid cyc %0d want 2", obs_first_rv); end
    n_checks++; if (obs_n !== 4) begin n_fail++; $display("FAIL quad_count: got %0d want 4", obs_n); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs_wo[i] !== exp_wo[i] || obs_data[i] !== exp_d[i]) begin
        n_fail++; $display("FAIL quad_word%0d: wo %0d data %0d want wo %0d data %0d", i, obs_wo[i], obs_data[i], exp_wo[i], exp_d[i]);
      end
    end
    n_checks++; if (obs_done_cyc !== 5 || obs_nxm !== 1'b0) begin n_fail++; $display("FAIL quad_done: cyc %0d nxm %b want 5 0", obs_done_cyc, obs_nxm); end
  endtask

  task automatic test_half_mask();
    run_xfer(22'o500, 4'b1100, 36'o100, 1'b1, -1, 40);
    n_checks++; if (obs_n !== 2) begin n_fail++; $display("FAIL half_count: got %0d want 2", obs_n); end
    n_checks++; if (obs_wo[0] !== 2'd0 || obs_wo[1] !== 2'd1) begin n_fail++; $display("FAIL half_wo: got %0d %0d want 0 1", obs_wo[0], obs_wo[1]); end
    n_checks++; if (obs_data[0] !== 36'o100 || obs_data[1] !== 36'o101) begin n_fail++; $display("FAIL half_data: got %o %o want 100 101", obs_data[0], obs_data[1]); end
    n_checks++; if (obs_done_cyc !== 3) begin n_fail++; $display("FAIL half_done: cyc %0d want 3", obs_done_cyc); end
    n_checks++; if (obs_hold_ok !== 1'b1) begin n_fail++; $display("FAIL half_hold: ADR/RQ changed before done, got %b want 1", obs_hold_ok); end
  endtask

  task automatic test_gap_mask();
    run_xfer(22'o14, 4'b1010, 36'o200, 1'b1, -1, 40);
    n_checks++; if (obs_n !== 2) begin n_fail++; $display("FAIL gap_count: got %0d want 2", obs_n); end
    n_checks++; if (obs_wo[0] !== 2'd0 || obs_wo[1] !== 2'd2) begin n_fail++; $display("FAIL gap_wo: got %0d %0d want 0 2", obs_wo[0], obs_wo[1]); end
    n_checks++; if (obs_data[0] !== 36'o200 || obs_data[1] !== 36'o202) begin n_fail++; $display("FAIL gap_data: got %o %o want 200 202", obs_data[0], obs_data[1]); end
    n_checks++; if (obs_done_cyc !== 4 || obs_nxm !== 1'b0) begin n_fail++; $display("FAIL gap_done: cyc %0d nxm %b want 4 0", obs_done_cyc, obs_nxm); end
  endtask

  task automatic test_timeout();
    run_xfer(22'o3000, 4'b1111, 36'd0, 1'b0, -1, 100);
    n_checks++; if (obs_done_cyc - obs_start_cyc !== 64 || obs_done_cyc < 0) begin n_fail++; $display("FAIL tmo_done: done %0d start %0d want 64 apart", obs_done_cyc, obs_start_cyc); end
    n_checks++; if (obs_nxm !== 1'b1) begin n_fail++; $display("FAIL tmo_nxm: got %b want 1", obs_nxm); end
    n_checks++; if (obs_n !== 0) begin n_fail++; $display("FAIL tmo_rdvalid: got %0d want 0", obs_n); end
  endtask

  task automatic test_parity();
    logic exp_par;
`ifdef SBUS_PARITY_CHK_EN
    exp_par = 1'b1;
`else
    exp_par = 1'b0;
`endif
    run_xfer(22'o2000, 4'b1111, 36'o7070, 1'b1, 1, 40);
    n_checks++; if (obs_n !== 4) begin n_fail++; $display("FAIL par_count: got %0d want 4", obs_n); end
    n_checks++; if (obs_data[1] !== 36'o7071) begin n_fail++; $display("FAIL par_word: got %o want 7071", obs_data[1]); end
    n_checks++; if (obs_done_cyc < 0 || obs_par !== exp_par) begin n_fail++; $display("FAIL par_flag: done %0d par_err %b want %b", obs_done_cyc, obs_par, exp_par); end
    run_xfer(22'o2000, 4'b1111, 36'o7070, 1'b1, -1, 40);
    n_checks++; if (obs_done_cyc < 0 || obs_par !== 1'b0) begin n_fail++; $display("FAIL par_clean: done %0d par_err %b want 0", obs_done_cyc, obs_par); end
  endtask

  task automatic test_zero_mask();
    run_xfer(22'o4000, 4'b0000, 36'd0, 1'b1, -1, 20);
    n_checks++; if (obs_start_cnt !== 0) begin n_fail++; $display("FAIL zero_start: got %0d want 0", obs_start_cnt); end
    n_checks++; if (obs_done_cyc !== 0 || obs_nxm !== 1'b0 || obs_n !== 0) begin n_fail++; $display("FAIL zero_done: cyc %0d nxm %b n %0d want 0 0 0", obs_done_cyc, obs_nxm, obs_n); end
  endtask

  task automatic test_crobar();
    bit seen_done, seen_start;
    @(negedge clk);
    req_valid = 1'b1; req_adr = 22'o6001; req_rq = 4'b1111;
    @(negedge clk);
    req_valid = 1'b0;
    seen_start = START;
    repeat (2) @(negedge clk);
    CROBAR = 1'b1;
    #1;
    n_checks++; if (seen_start !== 1'b1) begin n_fail++; $display("FAIL crob_start: got %b want 1", seen_start); end
    n_checks++; if (ADR !== 22'd0 || RQ !== 4'b0000 || START !== 1'b0) begin n_fail++; $display("FAIL crob_clear: ADR %o RQ %b START %b want 0", ADR, RQ, START); end
    n_checks++; if (done !== 1'b0 || rd_valid !== 1'b0 || nxm !== 1'b0 || par_err !== 1'b0) begin n_fail++; $display("FAIL crob_outs: done %b rdv %b nxm %b pe %b want 0", done, rd_valid, nxm, par_err); end
    @(negedge clk);
    CROBAR = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL crob_ready: got %b want 1", req_ready); end
    seen_done = 0;
    repeat (6) begin @(negedge clk); if (done) seen_done = 1; end
    n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL crob_nodone: got %b want 0", seen_done); end
    run_xfer(22'o1002, 4'b1111, 36'd1, 1'b1, -1, 40);
    n_checks++; if (obs_n !== 4 || obs_done_cyc !== 5 || obs_wo[0] !== 2'd2 || obs_data[0] !== 36'd3) begin
      n_fail++; $display("FAIL crob_after: n %0d done %0d wo0 %0d d0 %0d want 4 5 2 3", obs_n, obs_done_cyc, obs_wo[0], obs_data[0]);
    end
  endtask

  initial begin
    req_valid = 1'b0; req_adr = 22'd0; req_rq = 4'b0000;
    ACKN = 1'b0; DATA_VALID = 1'b0; D = 36'd0; DATA_PAR = 1'b0;
    test_reset();
    test_full_quad();
    test_half_mask();
    test_gap_mask();
    test_timeout();
    test_parity();
    test_zero_mask();
    test_crobar();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
